// File: rtl/pc_peak_finder.sv
// pc_peak_finder: streaming argmax over a 2^H_LOG2 x 2^W_LOG2 correlation
// surface; reports wrap-corrected peak shift plus runner-up magnitude.
module pc_peak_finder #(
  parameter int DATA_W = 16,
  parameter int W_LOG2 = 5,
  parameter int H_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sof,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W_LOG2-1:0] m_dx,
  output logic [H_LOG2-1:0] m_dy,
  output logic [DATA_W-1:0] m_peak,
  output logic [DATA_W-1:0] m_second,
  output logic              m_err
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t            state;
  logic [W_LOG2-1:0] col;
  logic [H_LOG2-1:0] row;
  logic [W_LOG2-1:0] pk_col;
  logic [H_LOG2-1:0] pk_row;
  logic [DATA_W-1:0] peak;
  logic [DATA_W-1:0] second;
  logic              err;

  logic              acc;
  logic              last;
  logic [W_LOG2-1:0] n_pk_col;
  logic [H_LOG2-1:0] n_pk_row;
  logic [DATA_W-1:0] n_peak;
  logic [DATA_W-1:0] n_second;

  assign acc  = s_valid && s_ready;
  assign last = (col == '1) && (row == '1);

  // Strict compares keep the earliest raster position on ties
  always_comb begin
    n_peak   = peak;
    n_second = second;
    n_pk_col = pk_col;
    n_pk_row = pk_row;
    if (s_data > peak) begin
      n_second = peak;
      n_peak   = s_data;
      n_pk_col = col;
      n_pk_row = row;
    end else if (s_data > second) begin
      n_second = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      m_dx     <= '0;
      m_dy     <= '0;
      m_peak   <= '0;
      m_second <= '0;
      m_err    <= 1'b0;
      col      <= '0;
      row      <= '0;
      pk_col   <= '0;
      pk_row   <= '0;
      peak     <= '0;
      second   <= '0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (acc && s_sof) begin
            peak   <= s_data;
            second <= '0;
            pk_col <= '0;
            pk_row <= '0;
            col    <= W_LOG2'(1);
            row    <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (acc && s_sof) begin
            peak   <= s_data;
            second <= '0;
            pk_col <= '0;
            pk_row <= '0;
            col    <= W_LOG2'(1);
            row    <= '0;
            err    <= 1'b1;
          end else if (acc) begin
            peak   <= n_peak;
            second <= n_second;
            pk_col <= n_pk_col;
            pk_row <= n_pk_row;
            // power-of-two width: col wraps to 0 by itself
            col    <= col + 1'b1;
            if (col == '1) row <= row + 1'b1;
            if (last) begin
              state    <= HOLD;
              s_ready  <= 1'b0;
              m_valid  <= 1'b1;
              m_dx     <= n_pk_col;
              m_dy     <= n_pk_row;
              m_peak   <= n_peak;
              m_second <= n_second;
              m_err    <= err;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            err     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_peak_finder.sv
// tb_pc_peak_finder: scoreboard bench for pc_peak_finder,
// one 32x32 instance and one 4x4 instance.
module tb_pc_peak_finder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, m_valid, m_err;
  logic [4:0]  m_dx, m_dy;
  logic [15:0] m_peak, m_second;

  logic        v4 = 1'b0;
  logic        sof4 = 1'b0;
  logic        mr4 = 1'b0;
  logic [15:0] d4 = '0;
  logic        r4, mv4, err4;
  logic [1:0]  dx4, dy4;
  logic [15:0] pk4, sc4;

  typedef struct {
    int dx;
    int dy;
    int peak;
    int second;
    int err;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];
  exp_t e, e4;
  int   tests = 0;
  int   fails = 0;
  int   frm[1024];

  always #5 clk = ~clk;

  pc_peak_finder #(.DATA_W(16), .W_LOG2(5), .H_LOG2(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_dx(m_dx), .m_dy(m_dy), .m_peak(m_peak), .m_second(m_second),
    .m_err(m_err)
  );

  pc_peak_finder #(.DATA_W(16), .W_LOG2(2), .H_LOG2(2)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(v4), .s_ready(r4), .s_sof(sof4), .s_data(d4),
    .m_valid(mv4), .m_ready(mr4),
    .m_dx(dx4), .m_dy(dy4), .m_peak(pk4), .m_second(sc4),
    .m_err(err4)
  );

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL result32: unexpected result dx=%0d dy=%0d peak=%0d",
                 $signed(m_dx), $signed(m_dy), m_peak);
      end else begin
        e = q.pop_front();
        if (int'($signed(m_dx)) != e.dx || int'($signed(m_dy)) != e.dy ||
            int'(m_peak) != e.peak || int'(m_second) != e.second ||
            int'(m_err) != e.err) begin
          fails++;
          $display("FAIL result32: got dx=%0d dy=%0d pk=%0d sc=%0d err=%0d need dx=%0d dy=%0d pk=%0d sc=%0d err=%0d",
                   $signed(m_dx), $signed(m_dy), m_peak, m_second, m_err,
                   e.dx, e.dy, e.peak, e.second, e.err);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mv4 && mr4) begin
      tests++;
      if (q4.size() == 0) begin
        fails++;
        $display("FAIL result4: unexpected result dx=%0d", $signed(dx4));
      end else begin
        e4 = q4.pop_front();
        if (int'($signed(dx4)) != e4.dx || int'($signed(dy4)) != e4.dy ||
            int'(pk4) != e4.peak || int'(sc4) != e4.second ||
            int'(err4) != e4.err) begin
          fails++;
          $display("FAIL result4: got dx=%0d dy=%0d pk=%0d sc=%0d err=%0d need dx=%0d dy=%0d pk=%0d sc=%0d err=%0d",
                   $signed(dx4), $signed(dy4), pk4, sc4, err4,
                   e4.dx, e4.dy, e4.peak, e4.second, e4.err);
        end
      end
    end
  end

  function automatic int wrap(input int v, input int n);
    return (v < n / 2) ? v : v - n;
  endfunction

  task automatic push(input int dx, input int dy, input int pk,
                      input int sc, input int err);
    exp_t x;
    x = '{dx, dy, pk, sc, err};
    q.push_back(x);
  endtask

  task automatic fill(input int bg);
    for (int i = 0; i < 1024; i++) frm[i] = bg;
  endtask

  task automatic expect_model(input int err);
    int best;
    int sec;
    best = 0;
    sec = 0;
    for (int i = 1; i < 1024; i++) if (frm[i] > frm[best]) best = i;
    for (int i = 0; i < 1024; i++) if (i != best && frm[i] > sec) sec = frm[i];
    push(wrap(best % 32, 32), wrap(best / 32, 32), frm[best], sec, err);
  endtask

  task automatic send(input bit sof, input int d);
    bit ok;
    int n;
    n = 0;
    s_valid = 1'b1;
    s_sof = sof;
    s_data = 16'(d);
    do begin
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: s_ready=%0b need 1", s_ready);
    end
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) send(i == 0, frm[i]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL wait_done: missing=%0d need 0", q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send4_frame(input int pk_idx, input int pk_val, input int bg);
    bit ok;
    int n;
    for (int i = 0; i < 16; i++) begin
      v4 = 1'b1;
      sof4 = (i == 0);
      d4 = 16'((i == pk_idx) ? pk_val : bg);
      n = 0;
      do begin
        ok = r4;
        @(posedge clk);
        #1;
        n++;
      end while (!ok && n < 50);
      if (!ok) begin
        tests++;
        fails++;
        $display("FAIL send4_timeout: r4=%0b need 1", r4);
      end
    end
    v4 = 1'b0;
    sof4 = 1'b0;
    tests++;
    if (mv4 !== 1'b1) begin
      fails++;
      $display("FAIL latency4: m_valid=%0b need 1", mv4);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({s_ready, m_valid, m_err, m_dx, m_dy, m_peak, m_second} !== '0 ||
        {r4, mv4, err4, dx4, dy4, pk4, sc4} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b pk=%0d sc=%0d need all 0",
               s_ready, m_valid, m_peak, m_second);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (s_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_early: s_ready=%0b need 0", s_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: s_ready=%0b need 1", s_ready);
    end
  endtask

  task automatic test_single_peak();
    int n;
    mr4 = 1'b1;
    q4.push_back('{1, -1, 500, 10, 0});
    send4_frame(13, 500, 10);
    q4.push_back('{-2, 0, 300, 7, 0});
    send4_frame(2, 300, 7);
    n = 0;
    while (q4.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (q4.size() != 0) begin
      fails++;
      $display("FAIL single_peak_done: missing=%0d need 0", q4.size());
      q4.delete();
    end
  endtask

  task automatic test_tie();
    m_ready = 1'b1;
    fill(0);
    frm[2 * 32 + 5] = 900;
    frm[7 * 32 + 30] = 900;
    push(5, 2, 900, 900, 0);
    stream(1024);
    wait_done();
  endtask

  task automatic test_wrap();
    fill(3);
    frm[31 * 32 + 16] = 1000;
    push(-16, -1, 1000, 3, 0);
    stream(1024);
    wait_done();
    fill(1);
    frm[15] = 70;
    push(15, 0, 70, 1, 0);
    stream(1024);
    wait_done();
  endtask

  task automatic test_back_pressure();
    m_ready = 1'b0;
    fill(5);
    frm[3 * 32 + 4] = 777;
    push(4, 3, 777, 5, 0);
    stream(1024);
    tests++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_latency: m_valid=%0b need 1", m_valid);
    end
    fill(2);
    frm[10 * 32 + 20] = 1234;
    push(-12, 10, 1234, 2, 0);
    s_valid = 1'b1;
    s_sof = 1'b1;
    s_data = 16'(frm[0]);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || $signed(m_dx) != 4 ||
          $signed(m_dy) != 3 || m_peak != 777 || m_second != 5 ||
          m_err !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold: vld=%0b rdy=%0b dx=%0d dy=%0d pk=%0d sc=%0d need 1 0 4 3 777 5",
                 m_valid, s_ready, $signed(m_dx), $signed(m_dy), m_peak, m_second);
      end
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: vld=%0b rdy=%0b need 0 1", m_valid, s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof = 1'b0;
    for (int i = 1; i < 1024; i++) send(1'b0, frm[i]);
    wait_done();
  endtask

  task automatic test_framing_error();
    for (int i = 0; i < 1024; i++) frm[i] = i % 50;
    frm[50] = 60000;
    stream(100);
    frm[50] = 0;
    frm[33] = 5000;
    push(1, 1, 5000, 49, 1);
    stream(1024);
    wait_done();
    for (int i = 0; i < 1024; i++) frm[i] = $urandom_range(0, 4000);
    expect_model(0);
    stream(1024);
    wait_done();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 1024; i++) frm[i] = i % 100;
    frm[10] = 9000;
    stream(300);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({s_ready, m_valid, m_err, m_dx, m_dy, m_peak, m_second} !== '0) begin
      fails++;
      $display("FAIL reset_mid: rdy=%0b vld=%0b pk=%0d sc=%0d need all 0",
               s_ready, m_valid, m_peak, m_second);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 40000);
    send(1'b0, 40000);
    fill(3);
    frm[5 * 32 + 7] = 400;
    push(7, 5, 400, 3, 0);
    stream(1024);
    wait_done();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 1024; i++) frm[i] = $urandom_range(0, 65535);
      expect_model(0);
      stream(1024);
    end
    wait_done();
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_tie();
    test_wrap();
    test_back_pressure();
    test_framing_error();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
